// File: rtl/adc_spin_integrator.sv
// ADC spin-window integrator: delay after trigger, then num_spins windows of len samples, each shifted and
// issued as one val_out pulse. Optional clamping of results under `SPIN_INT_SAT_EN`.
module adc_spin_integrator #(
  parameter int unsigned delay_reg = 2,
  parameter int unsigned len_reg   = 3,
  parameter int unsigned spins_reg = 4,
  parameter int unsigned shift_reg = 5,
  parameter int unsigned in_bits   = 16,
  parameter int unsigned out_bits  = 16,
  parameter int unsigned acc_bits  = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         gpio_in,
  input  logic [in_bits-1:0]  adc_in,
  input  logic                adc_valid,
  input  logic                trig_in,
  output logic [out_bits-1:0] val_out,
  output logic                val_out_valid,
  output logic                busy,
  output logic                sat_flag
);

  // GPIO bus: bit 31 write strobe, [15:8] address, [7:0] data
  localparam int unsigned GPIO_W_CLK_BIT = 31;

  typedef enum logic [1:0] {IDLE, DELAY, INTEG} state_t;

  logic                w_clk;
  logic [7:0]          gpio_addr;
  logic [7:0]          gpio_data;
  logic                gpio_unused;
  logic                arm;
  logic                addr_hit;
  logic                wr_en;
  logic [15:0]         delay_r, len_r, spins_r;
  logic [4:0]          shift_r;

  logic [15:0]         delay_s, len_s, spins_s;
  logic [4:0]          shift_s;
  logic [15:0]         cnt, spin_cnt;
  logic signed [acc_bits-1:0] acc, adc_ext, sum, shifted;
  logic [out_bits-1:0] res;
  logic                sat_hit;

  state_t state, state_n;
  logic   start, take, emit;

  assign w_clk       = gpio_in[GPIO_W_CLK_BIT];
  assign gpio_addr   = gpio_in[15:8];
  assign gpio_data   = gpio_in[7:0];
  assign gpio_unused = ^gpio_in[30:16];

  assign addr_hit = (gpio_addr == 8'(delay_reg)) || (gpio_addr == 8'(len_reg)) ||
                    (gpio_addr == 8'(spins_reg)) || (gpio_addr == 8'(shift_reg));
  assign wr_en    = w_clk & arm & addr_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm     <= 1'b1;
      delay_r <= '0;
      len_r   <= '0;
      spins_r <= '0;
      shift_r <= '0;
    end else begin
      if (!w_clk)     arm <= 1'b1;
      else if (wr_en) arm <= 1'b0;
      if (wr_en) begin
        if (gpio_addr == 8'(delay_reg)) delay_r <= {delay_r[7:0], gpio_data};
        if (gpio_addr == 8'(len_reg))   len_r   <= {len_r[7:0], gpio_data};
        if (gpio_addr == 8'(spins_reg)) spins_r <= {spins_r[7:0], gpio_data};
        if (gpio_addr == 8'(shift_reg)) shift_r <= gpio_data[4:0];
      end
    end
  end

  assign adc_ext = {{(acc_bits-in_bits){adc_in[in_bits-1]}}, adc_in};
  assign sum     = acc + adc_ext;
  assign shifted = sum >>> shift_s;

`ifdef SPIN_INT_SAT_EN
  logic fits;
  assign fits    = (shifted[acc_bits-1:out_bits-1] == '0) || (shifted[acc_bits-1:out_bits-1] == '1);
  assign sat_hit = ~fits;
  assign res     = fits ? shifted[out_bits-1:0]
                 : (shifted[acc_bits-1] ? {1'b1, {(out_bits-1){1'b0}}} : {1'b0, {(out_bits-1){1'b1}}});
`else
  logic shift_unused;
  assign shift_unused = ^shifted[acc_bits-1:out_bits];
  assign sat_hit      = 1'b0;
  assign res          = shifted[out_bits-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    take    = 1'b0;
    emit    = 1'b0;
    case (state)
      IDLE: if (trig_in && spins_r != '0) begin
        start   = 1'b1;
        state_n = (delay_r != '0) ? DELAY : INTEG;
      end
      DELAY: if (adc_valid && cnt == delay_s - 16'd1) state_n = INTEG;
      INTEG: if (adc_valid) begin
        take = 1'b1;
        if (cnt == len_s - 16'd1) begin
          emit = 1'b1;
          if (spin_cnt == spins_s - 16'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_s       <= '0;
      len_s         <= '0;
      spins_s       <= '0;
      shift_s       <= '0;
      cnt           <= '0;
      spin_cnt      <= '0;
      acc           <= '0;
      val_out       <= '0;
      val_out_valid <= 1'b0;
    end else begin
      val_out_valid <= emit;
      if (start) begin
        delay_s  <= delay_r;
        len_s    <= (len_r == '0) ? 16'd1 : len_r;
        spins_s  <= spins_r;
        shift_s  <= shift_r;
        cnt      <= '0;
        spin_cnt <= '0;
        acc      <= '0;
      end else if (state == DELAY && adc_valid) begin
        cnt <= (state_n == INTEG) ? 16'd0 : cnt + 16'd1;
      end else if (take) begin
        // Window closes on this sample; the next valid sample starts a fresh sum.
        if (emit) begin
          acc      <= '0;
          cnt      <= '0;
          spin_cnt <= spin_cnt + 16'd1;
          val_out  <= res;
        end else begin
          acc <= sum;
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

`ifdef SPIN_INT_SAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 sat_flag <= 1'b0;
    else if (start)           sat_flag <= 1'b0;
    else if (emit && sat_hit) sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spin_integrator.sv
// Scoreboard bench for adc_spin_integrator: expected window results are queued as samples are driven
// and compared when val_out_valid pulses.
module tb_adc_spin_integrator;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_in;
  logic [15:0] adc_in;
  logic        adc_valid;
  logic        trig_in;
  logic [15:0] val_out;
  logic        val_out_valid;
  logic        busy;
  logic        sat_flag;

  adc_spin_integrator dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .adc_in(adc_in), .adc_valid(adc_valid),
    .trig_in(trig_in), .val_out(val_out), .val_out_valid(val_out_valid), .busy(busy),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] v;
    logic        busy;
    logic        sat;
  } exp_t;

  exp_t   sb[$];
  int     ptimes[$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     cfg_len, cfg_spins, cfg_sh;
  longint w_sum;
  int     w_n, w_spin;
  bit     exp_sat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (val_out_valid === 1'b1) begin
      ptimes.push_back(cyc);
      check("pulse_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("val_out", 32'(val_out), 32'(e.v));
        check("busy_at_pulse", 32'(busy), 32'(e.busy));
        check("sat_flag", 32'(sat_flag), 32'(e.sat));
      end
    end
  end

  function automatic exp_t model(input longint s, input int sh, input bit busy_after);
    longint q;
    exp_t   r;
    q = s >>> sh;
    r.busy = busy_after;
`ifdef SPIN_INT_SAT_EN
    if (q > 32767)       begin r.v = 16'h7FFF; exp_sat = 1'b1; end
    else if (q < -32768) begin r.v = 16'h8000; exp_sat = 1'b1; end
    else                 r.v = q[15:0];
`else
    r.v = q[15:0];
`endif
    r.sat = exp_sat;
    return r;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    gpio_in = {1'b1, 15'd0, a, d};
    @(negedge clk);
    gpio_in = '0;
    @(negedge clk);
  endtask

  task automatic wr16(input logic [7:0] a, input logic [15:0] v);
    wr(a, v[15:8]);
    wr(a, v[7:0]);
  endtask

  task automatic config_all(input int dly, input int len, input int spins, input int sh);
    wr16(8'd2, dly[15:0]);
    wr16(8'd3, len[15:0]);
    wr16(8'd4, spins[15:0]);
    wr(8'd5, sh[7:0]);
    cfg_len = (len == 0) ? 1 : len;
    cfg_spins = spins;
    cfg_sh = sh;
  endtask

  task automatic start_round();
    w_sum = 0; w_n = 0; w_spin = 0; exp_sat = 1'b0;
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    check("busy_after_trig", 32'(busy), 1);
  endtask

  task automatic feed(input int v, input bit with_trig);
    adc_in = v[15:0]; adc_valid = 1'b1; trig_in = with_trig;
    w_sum += v; w_n++;
    if (w_n == cfg_len) begin
      w_spin++;
      sb.push_back(model(w_sum, cfg_sh, w_spin != cfg_spins));
      w_sum = 0; w_n = 0;
    end
    @(negedge clk);
    adc_valid = 1'b0; trig_in = 1'b0;
  endtask

  task automatic discard(input int v);
    adc_in = v[15:0]; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic gap();
    adc_in = 16'h1234; adc_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; gpio_in = '0; adc_in = '0; adc_valid = 1'b0; trig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_val_out", 32'(val_out), 0);
    check("rst_valid", 32'(val_out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sat", 32'(sat_flag), 0);
    rst = 1'b1;
    @(negedge clk);

    // Two contiguous windows of four
    config_all(0, 4, 2, 0);
    ptimes.delete();
    start_round();
    for (int i = 1; i <= 8; i++) feed(i, 1'b0);
    drain("t1");
    check("t1_pulse_count", 32'(ptimes.size()), 2);
    if (ptimes.size() == 2) check("t1_pulse_spacing", 32'(ptimes[1] - ptimes[0]), 4);
    check("t1_busy_end", 32'(busy), 0);

    // Delay discards three samples; trigger coinciding with the final emit is ignored
    config_all(3, 2, 1, 1);
    start_round();
    for (int i = 0; i < 3; i++) discard(100);
    feed(40, 1'b0);
    feed(60, 1'b1);
    drain("t2");
    check("t2_busy_after_trig_at_emit", 32'(busy), 0);

    // Valid gaps stall counting
    config_all(0, 4, 1, 0);
    start_round();
    for (int i = 0; i < 4; i++) begin
      feed(-5, 1'b0);
      gap();
    end
    drain("t3");

    // Largest window of full-scale samples
    config_all(0, 65535, 1, 0);
    start_round();
    for (int i = 0; i < 65535; i++) feed(32'h7FFF, 1'b0);
    drain("t4");

    // Mid-round register write and retrigger affect only the next round
    config_all(0, 2, 1, 0);
    start_round();
    feed(7, 1'b0);
    wr16(8'd3, 16'd8);
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    check("t5_busy_retrig", 32'(busy), 1);
    feed(9, 1'b0);
    drain("t5a");
    check("t5_busy_end", 32'(busy), 0);
    cfg_len = 8;
    start_round();
    for (int i = 0; i < 8; i++) feed(3, 1'b0);
    drain("t5b");

    // spins=0 leaves the trigger without effect
    wr16(8'd4, 16'd0);
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    check("t5_spins0_busy", 32'(busy), 0);
    @(negedge clk);
    check("t5_spins0_busy_later", 32'(busy), 0);
    wr16(8'd4, 16'd1);

    // Held write strobe shifts len only once: 0x0008 -> 0x0805
    gpio_in = {1'b1, 15'd0, 8'd3, 8'h05};
    repeat (10) @(negedge clk);
    gpio_in = '0;
    @(negedge clk);
    cfg_len = 16'h0805;
    start_round();
    for (int i = 0; i < 16'h0805; i++) feed(1, 1'b0);
    drain("t6");

    // Reset mid-integration aborts without a pulse and clears config
    wr16(8'd3, 16'd4);
    cfg_len = 4;
    start_round();
    feed(1, 1'b0);
    feed(1, 1'b0);
    rst = 1'b0;
    #1;
    check("t7_rst_val_out", 32'(val_out), 0);
    check("t7_rst_valid", 32'(val_out_valid), 0);
    check("t7_rst_busy", 32'(busy), 0);
    check("t7_rst_sat", 32'(sat_flag), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    check("t7_busy_after_reset_trig", 32'(busy), 0);
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
